image_streamer: RTL

IMAGE_STREAMER -- requirements
Module: image_streamer

---
 rtl/image_streamer_if.sv | 23 ++
 rtl/image_streamer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/image_streamer_if.sv
// Image RAM read port and pixel stream handshake shared by image_streamer and its neighbours.
interface image_streamer_if #(
   parameter int DATA_W = 32,
   parameter int AW     = 10
);
   logic [AW-1:0]     ram_addr;
   logic              ram_rden;
   logic [DATA_W-1:0] ram_q;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic              out_last;

   modport master (
      output ram_addr, ram_rden, out_data, out_valid, out_last,
      input  ram_q, out_ready
   );

   modport slave (
      input  ram_addr, ram_rden, out_data, out_valid, out_last,
      output ram_q, out_ready
   );
endinterface

// File: rtl/image_streamer.sv
// Streams one DEPTH-word frame from the image RAM to the classifier through a 2-entry FIFO.
// Defining INK_COUNT_EN adds a counter of nonzero words transferred (ink_count).
module image_streamer #(
   parameter int DEPTH  = 1024,
   parameter int DATA_W = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             abort,
   image_streamer_if.master bus,
   output logic             busy,
   output logic             done,
   output logic [10:0]      ink_count
);
   localparam int AW = 10;
   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            state_q, state_d, nxt_s;
   logic [AW-1:0]     rd_idx_q, rd_idx_d;
   logic [AW-1:0]     out_idx_q, out_idx_d;
   logic              pend_q, pend_d;
   logic [1:0]        cnt_q, cnt_d;
   logic              wr_ptr_q, wr_ptr_d;
   logic              rd_ptr_q, rd_ptr_d;
   logic [DATA_W-1:0] mem_q [2];
   logic [DATA_W-1:0] mem_d [2];
   logic              accept_s, pop_s, wr_s, issue_s, head_last_s;
   logic [2:0]        occ_s;
   logic [DATA_W-1:0] head_s;

   // Handshake decode; a read is allowed while post-pop occupancy plus the in-flight read is below 2.
   always_comb begin
      head_s      = mem_q[rd_ptr_q];
      pop_s       = (cnt_q != 2'd0) && bus.out_ready;
      accept_s    = (state_q == S_IDLE) && start && !abort;
      occ_s       = {1'b0, cnt_q} + {2'b00, pend_q} - {2'b00, pop_s};
      issue_s     = (state_q == S_FETCH) && !abort && (occ_s < 3'd2);
      wr_s        = pend_q && !abort;
      head_last_s = (out_idx_q == LAST_IDX);
   end

   // Frame sequencing; abort overrides every transition.
   always_comb begin
      nxt_s     = state_q;
      rd_idx_d  = rd_idx_q;
      out_idx_d = (pop_s && !head_last_s) ? out_idx_q + 10'd1 : out_idx_q;
      case (state_q)
         S_IDLE: begin
            if (accept_s) begin
               nxt_s     = S_FETCH;
               rd_idx_d  = 10'd0;
               out_idx_d = 10'd0;
            end else begin
               nxt_s = S_IDLE;
            end
         end
         S_FETCH: begin
            if (issue_s && (rd_idx_q == LAST_IDX)) begin
               nxt_s = S_DRAIN;
            end else if (issue_s) begin
               rd_idx_d = rd_idx_q + 10'd1;
            end else begin
               nxt_s = S_FETCH;
            end
         end
         S_DRAIN: begin
            if (pop_s && head_last_s) begin
               nxt_s = S_DONE;
            end else begin
               nxt_s = S_DRAIN;
            end
         end
         S_DONE:  nxt_s = S_IDLE;
         default: nxt_s = S_IDLE;
      endcase
      state_d = abort ? S_IDLE : nxt_s;
   end

   // 2-entry FIFO fed by the read returning one cycle after issue; abort flushes it.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      pend_d   = issue_s;
      if (abort) begin
         cnt_d    = 2'd0;
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
      end else begin
         if (wr_s) begin
            mem_d[wr_ptr_q] = bus.ram_q;
            wr_ptr_d        = ~wr_ptr_q;
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = ~rd_ptr_q;
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         cnt_d = cnt_q + {1'b0, wr_s} - {1'b0, pop_s};
      end
   end

   // State, index and FIFO registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         rd_idx_q  <= 10'd0;
         out_idx_q <= 10'd0;
         pend_q    <= 1'b0;
         cnt_q     <= 2'd0;
         wr_ptr_q  <= 1'b0;
         rd_ptr_q  <= 1'b0;
         mem_q[0]  <= {DATA_W{1'b0}};
         mem_q[1]  <= {DATA_W{1'b0}};
      end else begin
         state_q   <= state_d;
         rd_idx_q  <= rd_idx_d;
         out_idx_q <= out_idx_d;
         pend_q    <= pend_d;
         cnt_q     <= cnt_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         mem_q[0]  <= mem_d[0];
         mem_q[1]  <= mem_d[1];
      end
   end

   assign bus.ram_addr  = rd_idx_q;
   assign bus.ram_rden  = issue_s;
   assign bus.out_data  = head_s;
   assign bus.out_valid = (cnt_q != 2'd0);
   assign bus.out_last  = (cnt_q != 2'd0) && head_last_s;
   assign busy          = (state_q != S_IDLE);
   assign done          = (state_q == S_DONE);

`ifdef INK_COUNT_EN
   logic [10:0] ink_q, ink_d;

   // Saturating count of nonzero words, cleared on an accepted start and held after done.
   always_comb begin
      if (accept_s) begin
         ink_d = 11'd0;
      end else if (pop_s && (head_s != {DATA_W{1'b0}}) && (ink_q != 11'd1024)) begin
         ink_d = ink_q + 11'd1;
      end else begin
         ink_d = ink_q;
      end
   end

   // Ink counter register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ink_q <= 11'd0;
      end else begin
         ink_q <= ink_d;
      end
   end

   assign ink_count = ink_q;
`else
   assign ink_count = 11'd0;
`endif
endmodule
